// File: rtl/sfp_pkg.sv
// Shared definitions for the multi-channel special-function processor:
// FSM state encoding and saturation bound helpers.
package sfp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } sfp_state_e;

    localparam int DEF_COL     = 8;
    localparam int DEF_PSUM_BW = 16;
    localparam int DEF_LEN_BW  = 4;

    // Largest and smallest representable signed value for a bw-bit lane.
    function automatic longint sat_max_val(input int bw);
        return (longint'(1) <<< (bw - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min_val(input int bw);
        return -(longint'(1) <<< (bw - 1));
    endfunction

endpackage

// File: rtl/sfp_lane.sv
// One channel: signed saturating accumulator with optional ReLU on the output.
// Latency: accumulator updates on the edge after add_en; out_dat is combinational.
// Backpressure: none locally; the top qualifies clr/add_en with its handshakes.
module sfp_lane
    import sfp_pkg::*;
#(
    parameter int psum_bw = DEF_PSUM_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               add_en,
    input  logic               relu,
    input  logic [psum_bw-1:0] in_dat,
    output logic [psum_bw-1:0] out_dat
);

    localparam logic signed [psum_bw:0] SUM_MAX = (psum_bw + 1)'(sat_max_val(psum_bw));
    localparam logic signed [psum_bw:0] SUM_MIN = (psum_bw + 1)'(sat_min_val(psum_bw));

    logic signed [psum_bw-1:0] acc_q;
    logic signed [psum_bw-1:0] acc_d;
    logic signed [psum_bw:0]   sum_w;
    logic signed [psum_bw-1:0] sat_w;

    // One guard bit is enough: two in-range operands cannot overflow psum_bw+1.
    always_comb begin
        sum_w = $signed({acc_q[psum_bw-1], acc_q}) + $signed({in_dat[psum_bw-1], in_dat});
        if (sum_w > SUM_MAX) begin
            sat_w = SUM_MAX[psum_bw-1:0];
        end else if (sum_w < SUM_MIN) begin
            sat_w = SUM_MIN[psum_bw-1:0];
        end else begin
            sat_w = sum_w[psum_bw-1:0];
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = sat_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out_dat = (relu && acc_q[psum_bw-1]) ? '0 : acc_q;

endmodule

// File: rtl/sfp_accum_array.sv
// Accumulates cfg_len col-wide psum vectors per job, then emits one (optionally ReLU'd) vector.
// Latency: N back-to-back beats -> out_valid after the Nth accept edge; done one cycle after output accept.
// Backpressure: in_ready only in ACCUM, out_valid only in OUT; stalls extend the state, never drop data.
module sfp_accum_array
    import sfp_pkg::*;
#(
    parameter int col     = DEF_COL,
    parameter int psum_bw = DEF_PSUM_BW,
    parameter int len_bw  = DEF_LEN_BW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [len_bw-1:0]      cfg_len,
    input  logic                   cfg_relu,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [col*psum_bw-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [col*psum_bw-1:0] out_data,
    output logic                   done
);

    localparam logic [len_bw-1:0] LEN_ONE = len_bw'(1);

    sfp_state_e        state_q, state_d;
    logic [len_bw-1:0] cnt_q, cnt_d;
    logic [len_bw-1:0] len_q, len_d;
    logic              relu_q, relu_d;
    logic              done_q, done_d;

    logic start_acc;
    logic beat_acc;
    logic out_acc;
    logic last_beat;

    assign start_acc = (state_q == IDLE) && start;
    assign beat_acc  = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;
    assign last_beat = (cnt_q == len_q - LEN_ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        relu_d  = relu_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    // A zero length would never reach last_beat; treat it as a single beat.
                    len_d   = (cfg_len == '0) ? LEN_ONE : cfg_len;
                    relu_d  = cfg_relu;
                end
            end
            ACCUM: begin
                if (beat_acc) begin
                    if (last_beat) begin
                        state_d = OUT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_ONE;
                    end
                end
            end
            OUT: begin
                if (out_acc) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= LEN_ONE;
            relu_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            relu_q  <= relu_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign done      = done_q;

    for (genvar c = 0; c < col; c++) begin : g_lane
        sfp_lane #(
            .psum_bw(psum_bw)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .clr    (start_acc),
            .add_en (beat_acc),
            .relu   (relu_q),
            .in_dat (in_data[c*psum_bw +: psum_bw]),
            .out_dat(out_data[c*psum_bw +: psum_bw])
        );
    end

endmodule

// File: tb/tb_sfp_accum_array.sv
// Directed, table-driven bench for sfp_accum_array plus hand sequences for reset and start corner cases.
module tb_sfp_accum_array;

    localparam int COL = 8;
    localparam int PW  = 16;
    localparam int LB  = 4;
    localparam int W   = COL * PW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LB-1:0] cfg_len;
    logic          cfg_relu;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sfp_accum_array #(.col(COL), .psum_bw(PW), .len_bw(LB)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cfg_len  (cfg_len),
        .cfg_relu (cfg_relu),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .done     (done)
    );

    typedef struct packed {
        logic [LB-1:0]         len;
        logic                  relu;
        int                    exp_beats;
        logic                  gaps;
        int                    hold;
        logic [2:0][W-1:0]     beats;
        logic [W-1:0]          rest;
        logic [W-1:0]          exp_out;
    } vec_t;

    function automatic logic [W-1:0] all_l(input int v);
        logic [W-1:0] r;
        for (int c = 0; c < COL; c++) r[c*PW +: PW] = PW'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] lanes2(input int a, input int b);
        logic [W-1:0] r;
        r = '0;
        r[0 +: PW]  = PW'(a);
        r[PW +: PW] = PW'(b);
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [LB-1:0] len, input logic relu);
        start    = 1'b1;
        cfg_len  = len;
        cfg_relu = relu;
        @(negedge clk);
        start    = 1'b0;
        cfg_len  = '0;
        cfg_relu = ~relu;
    endtask

    task automatic finish_out(input string nm);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_done"}, W'(done), W'(1));
        chk({nm, "_idle"}, W'(busy), W'(0));
        @(negedge clk);
        chk({nm, "_done_once"}, W'(done), W'(0));
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int           acc;
        int           cyc;
        logic [W-1:0] held;
        pulse_start(v.len, v.relu);
        chk({nm, "_busy"}, W'({busy, in_ready}), W'(2'b11));
        acc = 0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            in_valid = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = (acc < 3) ? v.beats[acc] : v.rest;
            if (in_valid && in_ready) acc++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_beats"}, W'(acc), W'(v.exp_beats));
        if (!v.gaps) chk({nm, "_latency"}, W'(cyc), W'(v.exp_beats));
        chk({nm, "_out_valid"}, W'(out_valid), W'(1));
        held     = out_data;
        in_valid = 1'b1;
        in_data  = all_l(77);
        for (int h = 0; h < v.hold; h++) begin
            chk({nm, "_in_ready_out"}, W'(in_ready), W'(0));
            @(negedge clk);
            chk({nm, "_stable"}, out_data, held);
            chk({nm, "_hold_valid"}, W'(out_valid), W'(1));
        end
        in_valid = 1'b0;
        chk({nm, "_data"}, out_data, v.exp_out);
        finish_out(nm);
    endtask

    vec_t tbl[7];

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        cfg_len   = '0;
        cfg_relu  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        tbl[0] = '{len: 4'd3, relu: 1'b0, exp_beats: 3, gaps: 1'b0, hold: 0,
                   beats: {all_l(10), all_l(-2), all_l(5)}, rest: all_l(100), exp_out: all_l(13)};
        tbl[1] = '{len: 4'd2, relu: 1'b1, exp_beats: 2, gaps: 1'b0, hold: 0,
                   beats: {W'(0), lanes2(3, 4), lanes2(-7, 4)}, rest: all_l(100), exp_out: lanes2(0, 8)};
        tbl[2] = '{len: 4'd2, relu: 1'b0, exp_beats: 2, gaps: 1'b0, hold: 0,
                   beats: {W'(0), lanes2(3, 4), lanes2(-7, 4)}, rest: all_l(100), exp_out: lanes2(-4, 8)};
        tbl[3] = '{len: 4'd2, relu: 1'b0, exp_beats: 2, gaps: 1'b0, hold: 0,
                   beats: {W'(0), lanes2(30000, -30000), lanes2(30000, -30000)}, rest: all_l(100),
                   exp_out: lanes2(32767, -32768)};
        tbl[4] = '{len: 4'd3, relu: 1'b0, exp_beats: 3, gaps: 1'b1, hold: 5,
                   beats: {all_l(-10), all_l(2), all_l(1)}, rest: all_l(100), exp_out: all_l(-7)};
        tbl[5] = '{len: 4'd0, relu: 1'b0, exp_beats: 1, gaps: 1'b0, hold: 0,
                   beats: {all_l(100), all_l(100), all_l(6)}, rest: all_l(100), exp_out: all_l(6)};
        tbl[6] = '{len: 4'd15, relu: 1'b1, exp_beats: 15, gaps: 1'b0, hold: 2,
                   beats: {all_l(1), all_l(1), all_l(1)}, rest: all_l(1), exp_out: all_l(15)};

        @(negedge clk);
        @(negedge clk);
        chk("reset_ctrl", W'({busy, in_ready, out_valid, done}), W'(0));
        chk("reset_out_data", out_data, '0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            run_vec(tbl[k], $sformatf("vec%0d", k));
        end

        // start and cfg changes during ACCUM must not alter the running job
        pulse_start(4'd2, 1'b0);
        start    = 1'b1;
        cfg_len  = 4'd5;
        cfg_relu = 1'b1;
        in_valid = 1'b1;
        in_data  = all_l(-3);
        @(negedge clk);
        start   = 1'b0;
        in_data = all_l(-4);
        @(negedge clk);
        in_valid = 1'b0;
        chk("restart_out_valid", W'(out_valid), W'(1));
        chk("restart_data", out_data, all_l(-7));
        finish_out("restart");

        // Reset mid-job: partial sums and the job itself are discarded
        pulse_start(4'd4, 1'b0);
        in_valid = 1'b1;
        in_data  = all_l(50);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("midrst_ctrl", W'({busy, in_ready, out_valid, done}), W'(0));
        chk("midrst_out_data", out_data, '0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_no_done", W'({done, busy}), W'(0));
        run_vec('{len: 4'd1, relu: 1'b0, exp_beats: 1, gaps: 1'b0, hold: 0,
                  beats: {all_l(100), all_l(100), all_l(9)}, rest: all_l(100), exp_out: all_l(9)},
                "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sfp_accum_array.md
# sfp_accum_array

Multi-channel special-function processor, successor to the single-lane accumulate/ReLU unit. It sits between the output FIFO and PSUM SRAM. It accumulates a programmable number of `col`-wide partial-sum vectors per output position, using signed saturating arithmetic. It then emits one post-processed vector: optional ReLU, applied per channel. Input and output both use valid/ready handshakes.

## Interface
- `col`, default 8: number of channels (PE columns).
- `psum_bw`, default 16: signed partial-sum width per channel.
- `len_bw`, default 4: width of the accumulation-count field.
- `clk` input, 1: rising-edge clock.
- `reset` input, 1: reset is synchronous and active-high.
- `start` input, 1: begin a new accumulation job; honoured only in IDLE.
- `cfg_len` input, `len_bw`: vectors to accumulate; latched on accepted `start`; 0 is treated as 1.
- `cfg_relu` input, 1: apply ReLU on output; latched on accepted `start`.
- `busy` output, 1: high in any state other than IDLE.
- `in_valid` input, 1: `in_data` is valid.
- `in_ready` output, 1: high only in ACCUM.
- `in_data` input, `col*psum_bw`: channel c occupies bits [c*psum_bw +: psum_bw], signed.
- `out_valid` output, 1: high only in OUT.
- `out_ready` input, 1: consumer accepts `out_data`.
- `out_data` output, `col*psum_bw`: same packing as `in_data`.
- `done` output, 1: one-cycle pulse in the cycle after the output vector is accepted.

## Operation
- States:
  - IDLE: `start` goes to ACCUM. Accumulators are cleared to 0, the beat counter is cleared, and `len_q`/`relu_q` are latched.
  - ACCUM: each beat with `in_valid && in_ready` adds `in_data` into the accumulators and increments the counter. On the beat where counter == `len_q`-1, the next state is OUT.
  - OUT: holds until `out_valid && out_ready`, then goes to IDLE and `done` pulses next cycle.
- Per-channel add is signed and saturating:
  - Compute the sum in `psum_bw`+1 bits.
  - Above 2^(psum_bw-1)-1, clamp to the max; below -2^(psum_bw-1), clamp to the min.
  - Each lane saturates independently.
- ReLU (when `relu_q`=1): a negative accumulator outputs 0 and a non-negative one passes unchanged. With `relu_q`=0 the raw signed value passes.
- `out_data` is combinational from the accumulator registers and `relu_q`. It is stable for the whole OUT state.
- `start` outside IDLE is ignored; `cfg_*` changes after latch have no effect.
- `in_valid` while not in ACCUM: the beat is not consumed (`in_ready`=0). The producer must hold it.

## Timing
- Reset values:
  - state IDLE, accumulators 0, counter 0, `len_q`=1, `relu_q`=0.
  - `busy`, `in_ready`, `out_valid` and `done` all 0; `out_data`=0.
- Reset asserted mid-job aborts on the next edge with all values as above. The partial job is discarded, no `done` pulse is emitted, and nothing is output.
- `start` sampled at edge T: `busy` and `in_ready` are high from T+1.
- Latency: for N back-to-back beats accepted at edges T+1..T+N, `out_valid` goes high after edge T+N. If `out_ready` is held high, the vector is accepted at T+N+1 and `done` is high for the cycle after it.
- One vector can complete every N+2 cycles. Throughput is one input beat per cycle with no bubbles inside ACCUM.
- A stall on `in_valid` only extends ACCUM, and a stall on `out_ready` only extends OUT. No data is lost or duplicated.
- Counter wrap: `cfg_len` = 2^`len_bw`-1 is the maximum. The counter never exceeds `len_q`-1.

## Structure
- Shared package/include `sfp_pkg`:
  - state encoding constants: IDLE=2'd0, ACCUM=2'd1, OUT=2'd2.
  - saturation max/min helper constants derived from `psum_bw`.
- Sub-module `sfp_lane` (one channel):
  - accumulator register, saturating adder and ReLU mux.
  - inputs: clear, add-enable and `relu_q`.
  - instantiated `col` times in a generate loop.
- Top level holds the FSM, beat counter, config latches and handshake logic.

## Test plan
- Basic accumulate: col=8, `cfg_len`=3, `relu`=0, beats with every lane at 5, -2 and 10 → one output with every lane 13, `done` pulse, return to IDLE.
- ReLU: `cfg_len`=2, lane0 beats -7 and 3, lane1 beats 4 and 4, `relu`=1 → lane0 0, lane1 8. The same job with `relu`=0 → lane0 -4.
- Saturation: psum_bw=16, `cfg_len`=2, lane0 30000+30000 and lane1 -30000-30000 → 32767 and -32768 respectively.
- Backpressure: random `in_valid` gaps and `out_ready` held low for 5 cycles in OUT → `out_data` stable throughout, exactly one output, correct sum, and `in_ready`=0 during OUT.
- Reset mid-job: `cfg_len`=4, reset after 2 beats, then a new job with `cfg_len`=1 and beat 9 → output 9 (no residue) and no `done` from the aborted job.
- Edge cases:
  - `cfg_len`=0 behaves as 1.
  - `start` during ACCUM is ignored.
  - `cfg_len`=15 with `len_bw`=4 → exactly 15 beats accepted.
